// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word data memory.
// Each access runs IDLE -> ACCESS -> RESP; illegal addresses complete with err and no strobes.
module dmem_arbiter #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bad;
    logic        win;   // 1 = m1 owns this access
  } req_t;

  state_t      state_q, state_d;
  req_t        cur_q, pick;
  logic        last_q;  // 1 = m1 was granted last
  logic        any_req, pick_m1;
  logic [31:0] rdata0_q, rdata1_q, rd_val;

  function automatic logic illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > MAX_ADDR);
  endfunction

  // Lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req    = m0_req_i | m1_req_i;
    pick_m1    = m1_req_i && (!m0_req_i || !last_q);
    pick       = '0;
    pick.win   = pick_m1;
    pick.we    = pick_m1 ? m1_we_i    : m0_we_i;
    pick.addr  = pick_m1 ? m1_addr_i  : m0_addr_i;
    pick.wdata = pick_m1 ? m1_wdata_i : m0_wdata_i;
    pick.bad   = illegal(pick.addr);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_val = cur_q.bad ? 32'h0 : mem_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        cur_q  <= pick;
        last_q <= pick.win;
      end
      // Reads and illegal accesses both load rdata; legal writes leave it alone.
      if (state_q == ACCESS && (cur_q.bad || !cur_q.we)) begin
        if (cur_q.win) rdata1_q <= rd_val;
        else           rdata0_q <= rd_val;
      end
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    m0_gnt_o    = (state_q == ACCESS) && !cur_q.win;
    m1_gnt_o    = (state_q == ACCESS) &&  cur_q.win;
    MemWrite_o  = (state_q == ACCESS) && !cur_q.bad &&  cur_q.we;
    MemRead_o   = (state_q == ACCESS) && !cur_q.bad && !cur_q.we;
    m0_rvalid_o = (state_q == RESP) && !cur_q.win;
    m1_rvalid_o = (state_q == RESP) &&  cur_q.win;
    m0_err_o    = m0_rvalid_o && cur_q.bad;
    m1_err_o    = m1_rvalid_o && cur_q.bad;
    mem_addr_o  = cur_q.addr;
    mem_data_o  = cur_q.wdata;
    m0_rdata_o  = rdata0_q;
    m1_rdata_o  = rdata1_q;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 32, meaning data-memory size in bytes.
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have ports m0_req_i / m1_req_i  input  1  access request from requester 0 (pipeline MEM stage) / 1 (loader/debug).
REQ-005 The block SHALL have ports m0_we_i / m1_we_i  input  1  1 = word write, 0 = word read.
REQ-006 The block SHALL have ports m0_addr_i / m1_addr_i  input  32  byte address.
REQ-007 The block SHALL have ports m0_wdata_i / m1_wdata_i  input  32  write data.
REQ-008 The block SHALL have ports m0_gnt_o / m1_gnt_o  output  1  one-cycle pulse: request accepted.
REQ-009 The block SHALL have ports m0_rvalid_o / m1_rvalid_o  output  1  one-cycle pulse: access complete.
REQ-010 The block SHALL have ports m0_rdata_o / m1_rdata_o  output  32  read data, valid with rvalid.
REQ-011 The block SHALL have ports m0_err_o / m1_err_o  output  1  error flag, valid with rvalid.
REQ-012 The block SHALL have port mem_addr_o  output  32  address to data memory.
REQ-013 The block SHALL have port mem_data_o  output  32  write data to data memory.
REQ-014 The block SHALL have ports MemRead_o / MemWrite_o  output  1  data-memory read/write strobes.
REQ-015 The block SHALL have port mem_data_i  input  32  combinational read data from data memory.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-017 Requests SHALL be sampled only in IDLE; any req high in IDLE moves to ACCESS next edge; otherwise it stays in IDLE.
REQ-018 On entering ACCESS, the winner's we/addr/wdata SHALL be latched; requester inputs SHALL be ignored until the next IDLE.
REQ-019 Arbitration SHALL be round-robin: with only one request, that requester wins; with both, the requester not granted last wins; the last-grant pointer updates on each grant.
REQ-020 In ACCESS, the winner's gnt_o SHALL be high for exactly that cycle; ACCESS SHALL always go to RESP.
REQ-021 In ACCESS, mem_addr_o/mem_data_o SHALL equal the latched addr/wdata; MemWrite_o = we, MemRead_o = !we; both strobes SHALL be 0 in every other state.
REQ-022 For a read, mem_data_i SHALL be captured into the winner's rdata register at the edge ending ACCESS.
REQ-023 In RESP, the winner's rvalid_o SHALL be high for exactly that cycle; RESP SHALL always go to IDLE.
REQ-024 rdata_o SHALL hold its value until the next read completion for that requester; writes SHALL leave it unchanged.
REQ-025 An address is illegal if addr[1:0] != 0 or addr > MEM_BYTES-4 (32-bit compare, no wrap).
REQ-026 For an illegal address, the block SHALL still grant, hold both strobes at 0 in ACCESS, load rdata with 0, and assert err_o with rvalid in RESP.
REQ-027 err_o SHALL be 0 whenever rvalid_o is 0.
REQ-028 Latency SHALL be: request sampled in IDLE cycle N -> gnt in N+1 -> rvalid in N+2; the earliest next grant is N+4.
REQ-029 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-030 The non-winning requester SHALL see gnt, rvalid and err all 0.

Reset
REQ-031 While rst_i is high, the block SHALL be in IDLE with all gnt/rvalid/err/MemRead_o/MemWrite_o at 0, all rdata at 0, mem_addr_o/mem_data_o at 0, and the last-grant pointer at 1, so m0 wins the first tie.
REQ-032 Reset asserted during ACCESS SHALL drop the strobes immediately, with no memory write at the following edge and no rvalid for the aborted access.

Verification
REQ-033 The bench SHALL cover: m0 write addr 8, data 0xDEADBEEF, then m0 read addr 8 -> MemWrite_o high exactly one cycle; read rvalid with rdata 0xDEADBEEF and err 0.
REQ-034 The bench SHALL cover: m0 and m1 both reading from reset, held high -> grants in order m0, m1, m0, m1; each rvalid 2 cycles after its IDLE sample.
REQ-035 The bench SHALL cover: m1 read addr 6 and m1 read addr 32 (MEM_BYTES=32) -> no strobes; rvalid with err 1 and rdata 0 for both.
REQ-036 The bench SHALL cover: m1 read addr 28 -> legal; MemRead_o high one cycle with mem_addr_o=28; err 0.
REQ-037 The bench SHALL cover: rst_i pulsed during the ACCESS of an m0 write of 0x12345678 to addr 4 -> MemWrite_o falls immediately; a later read of addr 4 returns the prior contents; no rvalid is pulsed.
REQ-038 The bench SHALL cover: m0 read held high continuously -> gnt every 3 cycles; m0_rdata_o stable between rvalid pulses.
